// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-state encoding and defaults for the fetch stage.
package fetch_stage_pkg;
  typedef enum logic [1:0] {S_REQ, S_SQUASH, S_HOLD, S_HALTED} state_e;
  localparam logic [3:0]  OPC_HLT      = 4'hF;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
endpackage

// File: rtl/fetch_stage_cla.sv
// cla_16bit: 16-bit adder built from 4-bit carry-lookahead groups.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, mod 2^16
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [15:0] g, p;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    logic [15:0] c;
    logic        ci;
    c = '0;
    ci = cin;
    for (int k = 0; k < 16; k += 4) begin
      c[k]   = ci;
      c[k+1] = g[k] | (p[k] & ci);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & ci);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k]) | (p[k+2] & p[k+1] & p[k] & ci);
      ci = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1]) |
           (p[k+3] & p[k+2] & p[k+1] & g[k]) | (p[k+3] & p[k+2] & p[k+1] & p[k] & ci);
    end
    sum = p ^ c;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches 16-bit words over a req/ack handshake and feeds decode.
//   clk, rst                   : clock, synchronous active-high reset
//   imem_req/addr/ack/data     : instruction memory handshake (ack may come in the request cycle)
//   stall                      : decode holds the current output slot
//   branch_taken/branch_target : redirect from decode, highest priority
//   instr_out/pc_plus2_out     : fetched word and its address + 2
//   instr_valid                : output slot full
//   halted                     : HLT word captured, fetching stopped
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [3:0]  HLT_OPCODE = OPC_HLT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid,
  output logic        halted
);
  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, sq_addr_q, sq_addr_d, instr_q, instr_d, pp2_q, pp2_d, pc_inc;
  logic        valid_q, valid_d, slot_free, fetching, capture;
  cla_16bit u_inc (.a(pc_q), .b(16'd2), .cin(1'b0), .sum(pc_inc));
  // HOLD behaves like REQ once the slot frees, so a request goes out in the release cycle
  assign slot_free   = ~valid_q | ~stall;
  assign fetching    = state_q == S_REQ || state_q == S_HOLD;
  assign imem_req    = ~rst & ((fetching & slot_free) | state_q == S_SQUASH);
  // the orphaned request keeps its original address until its ack arrives
  assign imem_addr   = state_q == S_SQUASH ? sq_addr_q : pc_q;
  assign capture     = imem_req & imem_ack & fetching & ~branch_taken;
  assign instr_out    = instr_q;
  assign pc_plus2_out = pp2_q;
  assign instr_valid  = valid_q;
  assign halted       = state_q == S_HALTED;
  always_comb begin
    pc_d      = branch_taken ? branch_target : capture ? pc_inc : pc_q;
    instr_d   = capture ? imem_data : instr_q;
    pp2_d     = capture ? pc_inc : pp2_q;
    valid_d   = ~branch_taken & (capture | (valid_q & stall));
    sq_addr_d = branch_taken && state_q != S_SQUASH ? pc_q : sq_addr_q;
    state_d   = state_q;
    if (branch_taken)
      state_d = imem_req & ~imem_ack ? S_SQUASH : S_REQ;
    else if (capture)
      state_d = imem_data[15:12] == HLT_OPCODE ? S_HALTED : S_REQ;
    else if (state_q == S_SQUASH)
      state_d = imem_ack ? S_REQ : S_SQUASH;
    else if (fetching)
      state_d = slot_free ? S_REQ : S_HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      sq_addr_q <= RESET_PC;
      instr_q   <= '0;
      pp2_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sq_addr_q <= sq_addr_d;
      instr_q   <= instr_d;
      pp2_q     <= pp2_d;
      valid_q   <= valid_d;
    end
  end
endmodule
